// File: rtl/vdec_hs_sched_pkg.sv
// Shared constants, state encodings and helpers for the Viterbi decoder
// ping-pong scheduler.
package vdec_hs_pkg;

    localparam int MAX_BLK  = 29;
    localparam int TAIL_LEN = 8;
    localparam int SIZE_W   = 5;
    localparam int P7_W     = 6;

    typedef enum logic [1:0] {
        BK_FREE  = 2'd0,
        BK_FILL  = 2'd1,
        BK_FULL  = 2'd2,
        BK_DRAIN = 2'd3
    } bank_st_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fwd_st_t;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_RUN  = 2'd1,
        B_OUT  = 2'd2
    } bwd_st_t;

    // Clears every bit at or above 'size', so only the decoded payload survives.
    function automatic logic [MAX_BLK-1:0] mask_bits(input logic [MAX_BLK-1:0] bits,
                                                     input logic [SIZE_W-1:0]  size);
        return bits & ~({MAX_BLK{1'b1}} << size);
    endfunction

endpackage

// File: rtl/vdec_hs_sched_if.sv
// Job, forward/traceback engine and result handshakes of the scheduler.
interface vdec_hs_sched_if;
    import vdec_hs_pkg::*;

    logic                job_valid;
    logic                job_ready;
    logic [SIZE_W-1:0]   job_size;
    logic                fwd_start;
    logic                fwd_bank;
    logic                fwd_done;
    logic                bwd_start;
    logic                bwd_bank;
    logic [P7_W-1:0]     bwd_size_p7;
    logic                bwd_done;
    logic [MAX_BLK-1:0]  bwd_bits;
    logic                res_valid;
    logic                res_ready;
    logic [MAX_BLK-1:0]  res_bits;
    logic [SIZE_W-1:0]   res_size;
    logic                err_size;
    logic                busy;

    modport slave (
        input  job_valid, job_size, fwd_done, bwd_done, bwd_bits, res_ready,
        output job_ready, fwd_start, fwd_bank, bwd_start, bwd_bank, bwd_size_p7,
               res_valid, res_bits, res_size, err_size, busy
    );

    modport master (
        output job_valid, job_size, fwd_done, bwd_done, bwd_bits, res_ready,
        input  job_ready, fwd_start, fwd_bank, bwd_start, bwd_bank, bwd_size_p7,
               res_valid, res_bits, res_size, err_size, busy
    );

endinterface

// File: rtl/vdec_hs_bank_trk.sv
// Tracks the occupancy state and stored codeblock size of one ptram bank.
module vdec_hs_bank_trk
    import vdec_hs_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fill,
    input  logic              i_full,
    input  logic              i_drain,
    input  logic              i_free,
    input  logic [SIZE_W-1:0] i_size,
    output bank_st_t          o_state,
    output logic [SIZE_W-1:0] o_size
);

    bank_st_t          r_state;
    logic [SIZE_W-1:0] r_size;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BK_FREE;
            r_size  <= '0;
        end else if (i_fill) begin
            r_state <= BK_FILL;
            r_size  <= i_size;
        end else if (i_full) begin
            r_state <= BK_FULL;
        end else if (i_drain) begin
            r_state <= BK_DRAIN;
        end else if (i_free) begin
            r_state <= BK_FREE;
        end
    end

    assign o_state = r_state;
    assign o_size  = r_size;

endmodule

// File: rtl/vdec_hs_sched.sv
// Ping-pong scheduler: forward ACS fills one ptram bank while traceback drains the other.
//   state  | meaning
//   F_IDLE | waiting for a job and a free bank at wr_ptr
//   F_RUN  | forward block filling bank wr_ptr
//   B_IDLE | waiting for bank rd_ptr to become FULL
//   B_RUN  | traceback draining bank rd_ptr
//   B_OUT  | result held until consumed
module vdec_hs_sched #(
    parameter int MAX_BLK  = vdec_hs_pkg::MAX_BLK,
    parameter int TAIL_LEN = vdec_hs_pkg::TAIL_LEN
) (
    input  logic           clk,
    input  logic           rst_n,
    vdec_hs_sched_if.slave hs
);
    import vdec_hs_pkg::*;

    localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(MAX_BLK);
    localparam logic [P7_W-1:0]   P7_OFF = P7_W'(TAIL_LEN - 1);

    fwd_st_t r_fst, w_fst_nxt;
    bwd_st_t r_bst, w_bst_nxt;

    logic               r_live;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic               r_fwd_start;
    logic               r_fwd_bank;
    logic               r_err_size;
    logic               r_res_valid;
    logic [MAX_BLK-1:0] r_res_bits;
    logic [SIZE_W-1:0]  r_res_size;

    bank_st_t           w_bk_st   [2];
    logic [SIZE_W-1:0]  w_bk_size [2];
    logic [1:0]         w_fill, w_full, w_drain, w_free;
    logic               w_accept, w_size_ok, w_wr_tgl, w_rd_tgl;
    logic               w_bwd_start, w_res_load, w_bwd_act;

    assign w_accept  = hs.job_valid && hs.job_ready;
    assign w_size_ok = (hs.job_size != '0) && (hs.job_size <= MAX_SZ);

    always_comb begin
        w_fst_nxt = r_fst;
        w_fill    = '0;
        w_full    = '0;
        w_wr_tgl  = 1'b0;
        case (r_fst)
            F_IDLE: begin
                if (w_accept && w_size_ok) begin
                    w_fst_nxt         = F_RUN;
                    w_fill[r_wr_ptr]  = 1'b1;
                end
            end
            F_RUN: begin
                if (hs.fwd_done) begin
                    w_fst_nxt         = F_IDLE;
                    w_full[r_wr_ptr]  = 1'b1;
                    w_wr_tgl          = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_bst_nxt   = r_bst;
        w_drain     = '0;
        w_free      = '0;
        w_rd_tgl    = 1'b0;
        w_bwd_start = 1'b0;
        w_res_load  = 1'b0;
        case (r_bst)
            B_IDLE: begin
                if ((w_bk_st[r_rd_ptr] == BK_FULL) && !r_res_valid) begin
                    w_bst_nxt         = B_RUN;
                    w_bwd_start       = 1'b1;
                    w_drain[r_rd_ptr] = 1'b1;
                end
            end
            B_RUN: begin
                if (hs.bwd_done) begin
                    w_bst_nxt        = B_OUT;
                    w_free[r_rd_ptr] = 1'b1;
                    w_rd_tgl         = 1'b1;
                    w_res_load       = 1'b1;
                end
            end
            B_OUT: begin
                if (hs.res_ready) w_bst_nxt = B_IDLE;
            end
            default: w_bst_nxt = B_IDLE;
        endcase
    end

    // r_live keeps job_ready low while reset is held and on the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fst       <= F_IDLE;
            r_bst       <= B_IDLE;
            r_live      <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_fwd_start <= 1'b0;
            r_fwd_bank  <= 1'b0;
            r_err_size  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_bits  <= '0;
            r_res_size  <= '0;
        end else begin
            r_fst       <= w_fst_nxt;
            r_bst       <= w_bst_nxt;
            r_live      <= 1'b1;
            r_fwd_start <= |w_fill;
            r_err_size  <= w_accept && !w_size_ok;
            if (w_wr_tgl) r_wr_ptr <= ~r_wr_ptr;
            if (w_rd_tgl) r_rd_ptr <= ~r_rd_ptr;
            if (|w_fill)  r_fwd_bank <= r_wr_ptr;
            if (w_res_load) begin
                r_res_valid <= 1'b1;
                r_res_bits  <= mask_bits(hs.bwd_bits, w_bk_size[r_rd_ptr]);
                r_res_size  <= w_bk_size[r_rd_ptr];
            end else if ((r_bst == B_OUT) && hs.res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    vdec_hs_bank_trk u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_fill  (w_fill[0]),
        .i_full  (w_full[0]),
        .i_drain (w_drain[0]),
        .i_free  (w_free[0]),
        .i_size  (hs.job_size),
        .o_state (w_bk_st[0]),
        .o_size  (w_bk_size[0])
    );

    vdec_hs_bank_trk u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_fill  (w_fill[1]),
        .i_full  (w_full[1]),
        .i_drain (w_drain[1]),
        .i_free  (w_free[1]),
        .i_size  (hs.job_size),
        .o_state (w_bk_st[1]),
        .o_size  (w_bk_size[1])
    );

    // Traceback bank/size come straight from the tracker, stable until the drain completes.
    assign w_bwd_act      = w_bwd_start || (r_bst == B_RUN);
    assign hs.job_ready   = r_live && (r_fst == F_IDLE) && (w_bk_st[r_wr_ptr] == BK_FREE);
    assign hs.fwd_start   = r_fwd_start;
    assign hs.fwd_bank    = r_fwd_bank;
    assign hs.bwd_start   = w_bwd_start;
    assign hs.bwd_bank    = w_bwd_act && r_rd_ptr;
    assign hs.bwd_size_p7 = w_bwd_act ? (P7_W'(w_bk_size[r_rd_ptr]) + P7_OFF) : '0;
    assign hs.res_valid   = r_res_valid;
    assign hs.res_bits    = r_res_bits;
    assign hs.res_size    = r_res_size;
    assign hs.err_size    = r_err_size;
    assign hs.busy        = (w_bk_st[0] != BK_FREE) || (w_bk_st[1] != BK_FREE)
                            || (r_fst != F_IDLE) || r_res_valid;

endmodule

// File: tb/tb_vdec_hs_sched.sv
// Directed bench for vdec_hs_sched: single-job vector table plus ping-pong,
// stall, simultaneous-completion and reset sequences.
module tb_vdec_hs_sched;
    import vdec_hs_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    vdec_hs_sched_if hs ();

    vdec_hs_sched #(.MAX_BLK(29), .TAIL_LEN(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hs    (hs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  size;
        logic [28:0] bits;
        logic        err;
        logic [5:0]  p7;
        logic [28:0] res;
        int          dly;
    } vec_t;

    vec_t vecs [8];
    logic exp_bank;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        hs.job_valid = 1'b0;
        hs.job_size  = '0;
        hs.fwd_done  = 1'b0;
        hs.bwd_done  = 1'b0;
        hs.bwd_bits  = '0;
        hs.res_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".job_ready"}, 32'(hs.job_ready), 0);
        chk({tag, ".fwd_start"}, 32'(hs.fwd_start), 0);
        chk({tag, ".fwd_bank"},  32'(hs.fwd_bank), 0);
        chk({tag, ".bwd_start"}, 32'(hs.bwd_start), 0);
        chk({tag, ".bwd_bank"},  32'(hs.bwd_bank), 0);
        chk({tag, ".bwd_p7"},    32'(hs.bwd_size_p7), 0);
        chk({tag, ".res_valid"}, 32'(hs.res_valid), 0);
        chk({tag, ".res_bits"},  32'(hs.res_bits), 0);
        chk({tag, ".res_size"},  32'(hs.res_size), 0);
        chk({tag, ".err_size"},  32'(hs.err_size), 0);
        chk({tag, ".busy"},      32'(hs.busy), 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        vecs[0] = '{5'd29, 29'h1FFFFFFF, 1'b0, 6'd36, 29'h1FFFFFFF, 40};
        vecs[1] = '{5'd0,  29'h1FFFFFFF, 1'b1, 6'd0,  29'h0,        0};
        vecs[2] = '{5'd10, 29'h1FFFFFFF, 1'b0, 6'd17, 29'h3FF,      3};
        vecs[3] = '{5'd31, 29'h1FFFFFFF, 1'b1, 6'd0,  29'h0,        0};
        vecs[4] = '{5'd5,  29'h0ABCDEF3, 1'b0, 6'd12, 29'h13,       2};
        vecs[5] = '{5'd1,  29'h1FFFFFFE, 1'b0, 6'd8,  29'h0,        1};
        vecs[6] = '{5'd30, 29'h1FFFFFFF, 1'b1, 6'd0,  29'h0,        0};
        vecs[7] = '{5'd16, 29'h12345678, 1'b0, 6'd23, 29'h5678,     5};

        idle_inputs();
        #2;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst.job_ready", 32'(hs.job_ready), 1);
        chk("post_rst.busy", 32'(hs.busy), 0);

        // Single-job vectors; bank alternates only on legal jobs.
        exp_bank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("vec.job_ready", 32'(hs.job_ready), 1);
            hs.job_valid = 1'b1;
            hs.job_size  = vecs[i].size;
            step();
            hs.job_valid = 1'b0;
            chk("vec.err_size", 32'(hs.err_size), 32'(vecs[i].err));
            chk("vec.fwd_start", 32'(hs.fwd_start), 32'(!vecs[i].err));
            if (vecs[i].err) begin
                chk("vec.err_ready", 32'(hs.job_ready), 1);
                step();
                chk("vec.err_pulse_end", 32'(hs.err_size), 0);
                chk("vec.err_busy", 32'(hs.busy), 0);
            end else begin
                chk("vec.fwd_bank", 32'(hs.fwd_bank), 32'(exp_bank));
                chk("vec.busy_run", 32'(hs.busy), 1);
                repeat (vecs[i].dly) step();
                chk("vec.fwd_start_end", 32'(hs.fwd_start), 0);
                hs.fwd_done = 1'b1;
                step();
                hs.fwd_done = 1'b0;
                chk("vec.bwd_start", 32'(hs.bwd_start), 1);
                chk("vec.bwd_bank", 32'(hs.bwd_bank), 32'(exp_bank));
                chk("vec.bwd_p7", 32'(hs.bwd_size_p7), 32'(vecs[i].p7));
                step();
                chk("vec.bwd_start_end", 32'(hs.bwd_start), 0);
                chk("vec.bwd_p7_hold", 32'(hs.bwd_size_p7), 32'(vecs[i].p7));
                hs.bwd_bits = vecs[i].bits;
                hs.bwd_done = 1'b1;
                step();
                hs.bwd_done = 1'b0;
                chk("vec.res_valid", 32'(hs.res_valid), 1);
                chk("vec.res_bits", 32'(hs.res_bits), 32'(vecs[i].res));
                chk("vec.res_size", 32'(hs.res_size), 32'(vecs[i].size));
                hs.res_ready = 1'b1;
                step();
                hs.res_ready = 1'b0;
                chk("vec.res_valid_end", 32'(hs.res_valid), 0);
                chk("vec.busy_end", 32'(hs.busy), 0);
                exp_bank = ~exp_bank;
            end
        end

        // Ping-pong, full-bank stall, res_ready stall, simultaneous completions.
        do_reset();
        hs.fwd_done = 1'b1;
        hs.bwd_done = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        hs.bwd_done = 1'b0;
        chk("spur.res_valid", 32'(hs.res_valid), 0);
        chk("spur.bwd_start", 32'(hs.bwd_start), 0);
        chk("spur.busy", 32'(hs.busy), 0);
        chk("spur.job_ready", 32'(hs.job_ready), 1);

        hs.job_valid = 1'b1;
        hs.job_size  = 5'd10;
        step();
        hs.job_valid = 1'b0;
        chk("pp.a_fwd_bank", 32'(hs.fwd_bank), 0);
        hs.fwd_done = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        chk("pp.a_bwd_start", 32'(hs.bwd_start), 1);
        chk("pp.a_bwd_p7", 32'(hs.bwd_size_p7), 17);
        chk("pp.ready_b", 32'(hs.job_ready), 1);
        hs.job_valid = 1'b1;
        hs.job_size  = 5'd5;
        step();
        hs.job_valid = 1'b0;
        chk("pp.b_fwd_start", 32'(hs.fwd_start), 1);
        chk("pp.b_fwd_bank", 32'(hs.fwd_bank), 1);
        chk("pp.a_bwd_p7_hold", 32'(hs.bwd_size_p7), 17);
        hs.fwd_done = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        chk("pp.full_ready", 32'(hs.job_ready), 0);
        hs.job_valid = 1'b1;
        hs.job_size  = 5'd7;
        step();
        chk("pp.stall_ready", 32'(hs.job_ready), 0);
        chk("pp.stall_fwd", 32'(hs.fwd_start), 0);
        hs.bwd_bits = 29'h1FFFFFFF;
        hs.bwd_done = 1'b1;
        step();
        hs.bwd_done = 1'b0;
        chk("pp.a_res_valid", 32'(hs.res_valid), 1);
        chk("pp.a_res_bits", 32'(hs.res_bits), 32'h3FF);
        chk("pp.a_res_size", 32'(hs.res_size), 10);
        chk("pp.c_ready", 32'(hs.job_ready), 1);
        step();
        hs.job_valid = 1'b0;
        chk("pp.c_fwd_start", 32'(hs.fwd_start), 1);
        chk("pp.c_fwd_bank", 32'(hs.fwd_bank), 0);
        chk("pp.hold_bwd", 32'(hs.bwd_start), 0);
        step();
        chk("pp.hold_bwd2", 32'(hs.bwd_start), 0);
        chk("pp.hold_bits", 32'(hs.res_bits), 32'h3FF);
        hs.res_ready = 1'b1;
        step();
        hs.res_ready = 1'b0;
        chk("pp.a_consumed", 32'(hs.res_valid), 0);
        chk("pp.b_bwd_start", 32'(hs.bwd_start), 1);
        chk("pp.b_bwd_bank", 32'(hs.bwd_bank), 1);
        chk("pp.b_bwd_p7", 32'(hs.bwd_size_p7), 12);
        step();
        hs.bwd_done = 1'b1;
        step();
        hs.bwd_done = 1'b0;
        chk("pp.b_res_bits", 32'(hs.res_bits), 32'h1F);
        chk("pp.b_res_size", 32'(hs.res_size), 5);
        hs.res_ready = 1'b1;
        step();
        hs.res_ready = 1'b0;
        hs.fwd_done = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        chk("pp.c_bwd_bank", 32'(hs.bwd_bank), 0);
        chk("pp.c_bwd_p7", 32'(hs.bwd_size_p7), 14);
        hs.job_valid = 1'b1;
        hs.job_size  = 5'd3;
        step();
        hs.job_valid = 1'b0;
        chk("pp.d_fwd_bank", 32'(hs.fwd_bank), 1);
        hs.fwd_done = 1'b1;
        hs.bwd_done = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        hs.bwd_done = 1'b0;
        chk("sim.c_res_bits", 32'(hs.res_bits), 32'h7F);
        chk("sim.c_res_size", 32'(hs.res_size), 7);
        chk("sim.job_ready", 32'(hs.job_ready), 1);
        chk("sim.busy", 32'(hs.busy), 1);
        hs.res_ready = 1'b1;
        step();
        hs.res_ready = 1'b0;
        chk("sim.d_bwd_start", 32'(hs.bwd_start), 1);
        chk("sim.d_bwd_bank", 32'(hs.bwd_bank), 1);
        chk("sim.d_bwd_p7", 32'(hs.bwd_size_p7), 10);
        step();
        hs.bwd_bits = 29'h0000000F;
        hs.bwd_done = 1'b1;
        step();
        hs.bwd_done = 1'b0;
        chk("sim.d_res_bits", 32'(hs.res_bits), 32'h7);
        chk("sim.d_res_size", 32'(hs.res_size), 3);
        hs.res_ready = 1'b1;
        step();
        hs.res_ready = 1'b0;
        chk("sim.busy_end", 32'(hs.busy), 0);

        // Reset while traceback runs and a second job is filling bank 1.
        do_reset();
        hs.job_valid = 1'b1;
        hs.job_size  = 5'd20;
        step();
        hs.job_valid = 1'b0;
        hs.fwd_done  = 1'b1;
        step();
        hs.fwd_done  = 1'b0;
        chk("rr.bwd_p7", 32'(hs.bwd_size_p7), 27);
        hs.job_valid = 1'b1;
        hs.job_size  = 5'd6;
        step();
        hs.job_valid = 1'b0;
        chk("rr.second_bank", 32'(hs.fwd_bank), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rr");
        hs.fwd_done = 1'b1;
        hs.bwd_done = 1'b1;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        hs.bwd_done = 1'b0;
        chk("rr.no_result", 32'(hs.res_valid), 0);
        chk("rr.no_bwd", 32'(hs.bwd_start), 0);
        chk("rr.busy", 32'(hs.busy), 0);
        hs.job_valid = 1'b1;
        hs.job_size  = 5'd4;
        step();
        hs.job_valid = 1'b0;
        chk("rr.next_start", 32'(hs.fwd_start), 1);
        chk("rr.next_bank", 32'(hs.fwd_bank), 0);
        hs.fwd_done = 1'b1;
        step();
        hs.fwd_done = 1'b0;
        chk("rr.next_bwd_bank", 32'(hs.bwd_bank), 0);
        chk("rr.next_bwd_p7", 32'(hs.bwd_size_p7), 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
